register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 ROB_WIDTH, 4, ROB tag width.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 rdy_in  input  1  ready; low freezes all state.
REQ-005 clear_signal  input  1  misprediction flush from ROB.
REQ-006 issue_signal  input  1  instruction issued this cycle.
REQ-007 issue_rd_id  input  5  destination register of issued instruction.
REQ-008 issue_rob_tag  input  ROB_WIDTH  ROB line allocated to issued instruction.
REQ-009 issue_rs1_id / issue_rs2_id  input  5 each  source registers being looked up.
REQ-010 commit_signal  input  1  ROB commits a register write (ROB reg_done).
REQ-011 commit_rd_id  input  5  committed destination register.
REQ-012 commit_value  input  32  committed value.
REQ-013 commit_tag  input  ROB_WIDTH  ROB line of committed instruction.
REQ-014 rs1_value / rs2_value  output  32 each  architectural value of source.
REQ-015 rs1_busy / rs2_busy  output  1 each  1 = source awaits an in-flight ROB line.
REQ-016 rs1_tag / rs2_tag  output  ROB_WIDTH each  ROB line producing the source when busy.

Function
REQ-017 Storage: 32 x 32-bit values, 32 busy bits, 32 x ROB_WIDTH tags; register x0 always reads value 0, busy 0, tag 0.
REQ-018 Lookup outputs are combinational from current state plus same-cycle commit bypass.
REQ-019 Bypass: if commit_signal and commit_rd_id == rsN_id != 0 and reg busy with tag == commit_tag, rsN_value = commit_value, rsN_busy = 0.
REQ-020 Bypass does not apply when tag mismatches; output stays busy with stored tag.
REQ-021 Issue (rdy_in, issue_signal, ~clear_signal, issue_rd_id != 0): busy[rd] <= 1, tag[rd] <= issue_rob_tag.
REQ-022 Issue with issue_rd_id == 0: no state change.
REQ-023 Commit (rdy_in, commit_signal, commit_rd_id != 0): value[rd] <= commit_value regardless of tag.
REQ-024 Commit clears busy[rd] only when tag[rd] == commit_tag and no same-cycle issue to same rd.
REQ-025 Same-cycle issue and commit to same rd: value written, busy stays 1, tag becomes issue_rob_tag.
REQ-026 Commit is honoured while clear_signal is high (commit and flush arrive on same edge from ROB).
REQ-027 clear_signal with rdy_in: all busy bits <= 0 after the edge, values keep committed data; issue ignored that cycle.
REQ-028 rdy_in low: no value, busy or tag change; lookups remain combinational.
REQ-029 Lookup of a register being issued this cycle returns pre-issue state (ROB dependency on own rd handled upstream).

Reset
REQ-030 rst_in high: all values 0, all busy 0, all tags 0, immediately and independent of clk_in.
REQ-031 Reset mid-operation discards pending issues/commits in that cycle; first update after release is next rising edge with rst_in low.
REQ-032 Outputs after reset: rs*_value 0, rs*_busy 0, rs*_tag 0 for any lookup.

Verification
REQ-033 Reset, lookup rs1=5, rs2=0 -> values 0, busy 0, tags 0.
REQ-034 Issue rd=5 tag=3; next cycle lookup rs1=5 -> busy 1, tag 3; commit rd=5 tag=3 value 0xDEADBEEF same cycle -> rs1_value 0xDEADBEEF, busy 0 (bypass); next cycle busy 0.
REQ-035 Issue rd=7 tag=1, then rd=7 tag=2; commit rd=7 tag=1 value 0x11 -> value[7]=0x11, busy 1, tag 2.
REQ-036 Same-cycle issue rd=9 tag=4 and commit rd=9 tag=2 (stored tag 2) value 0x55 -> value 0x55, busy 1, tag 4.
REQ-037 Registers 3,4 busy; clear_signal with commit rd=3 value 0x77 -> value[3]=0x77, busy[3]=busy[4]=0; simultaneous issue rd=6 ignored.
REQ-038 Issue rd=0 tag=5, commit rd=0 value 0xFF -> x0 reads value 0, busy 0; rdy_in low with issue rd=8 -> busy[8] unchanged.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags.
// Same-cycle commit bypass feeds the dispatch lookup ports.
module register_file #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 issue_signal,
    input  logic [4:0]           issue_rd_id,
    input  logic [ROB_WIDTH-1:0] issue_rob_tag,
    input  logic [4:0]           issue_rs1_id,
    input  logic [4:0]           issue_rs2_id,
    input  logic                 commit_signal,
    input  logic [4:0]           commit_rd_id,
    input  logic [31:0]          commit_value,
    input  logic [ROB_WIDTH-1:0] commit_tag,
    output logic [31:0]          rs1_value,
    output logic [31:0]          rs2_value,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_WIDTH-1:0] rs1_tag,
    output logic [ROB_WIDTH-1:0] rs2_tag
);

    logic [31:0]          values [32];
    logic [31:0]          busy;
    logic [ROB_WIDTH-1:0] tags [32];

    logic issue_fire;
    logic commit_fire;
    logic commit_tag_match;
    logic commit_release;
    logic hit1;
    logic hit2;

    assign issue_fire  = issue_signal && !clear_signal
                         && (issue_rd_id != 5'd0);
    assign commit_fire = commit_signal && (commit_rd_id != 5'd0);

    assign commit_tag_match = (tags[commit_rd_id] == commit_tag);

    // A fresh issue to the same rd renames it again, so it stays busy.
    assign commit_release = commit_fire && commit_tag_match
                            && !(issue_fire
                                 && (issue_rd_id == commit_rd_id));

    assign hit1 = commit_signal
                  && (commit_rd_id == issue_rs1_id)
                  && busy[issue_rs1_id]
                  && (tags[issue_rs1_id] == commit_tag);

    assign hit2 = commit_signal
                  && (commit_rd_id == issue_rs2_id)
                  && busy[issue_rs2_id]
                  && (tags[issue_rs2_id] == commit_tag);

    always_comb begin
        rs1_value = 32'd0;
        rs1_busy  = 1'b0;
        rs1_tag   = '0;
        if (issue_rs1_id != 5'd0) begin
            rs1_tag = tags[issue_rs1_id];
            if (hit1) begin
                rs1_value = commit_value;
                rs1_busy  = 1'b0;
            end else begin
                rs1_value = values[issue_rs1_id];
                rs1_busy  = busy[issue_rs1_id];
            end
        end
    end

    always_comb begin
        rs2_value = 32'd0;
        rs2_busy  = 1'b0;
        rs2_tag   = '0;
        if (issue_rs2_id != 5'd0) begin
            rs2_tag = tags[issue_rs2_id];
            if (hit2) begin
                rs2_value = commit_value;
                rs2_busy  = 1'b0;
            end else begin
                rs2_value = values[issue_rs2_id];
                rs2_busy  = busy[issue_rs2_id];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                values[i] <= 32'd0;
                tags[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_fire) begin
                values[commit_rd_id] <= commit_value;
            end
            // Flush drops every rename but keeps committed data.
            if (clear_signal) begin
                busy <= 32'd0;
            end else begin
                if (commit_release) begin
                    busy[commit_rd_id] <= 1'b0;
                end
                if (issue_fire) begin
                    busy[issue_rd_id] <= 1'b1;
                    tags[issue_rd_id] <= issue_rob_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file.
// Behavioural model tracks architectural state per register.
module tb_register_file;

    localparam int RW = 4;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_signal;
    logic          issue_signal;
    logic [4:0]    issue_rd_id;
    logic [RW-1:0] issue_rob_tag;
    logic [4:0]    issue_rs1_id;
    logic [4:0]    issue_rs2_id;
    logic          commit_signal;
    logic [4:0]    commit_rd_id;
    logic [31:0]   commit_value;
    logic [RW-1:0] commit_tag;
    logic [31:0]   rs1_value;
    logic [31:0]   rs2_value;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [RW-1:0] rs1_tag;
    logic [RW-1:0] rs2_tag;

    int checks;
    int errors;

    logic [31:0]   m_val  [32];
    logic          m_busy [32];
    logic [RW-1:0] m_tag  [32];
    logic [31:0]   n_val  [32];
    logic          n_busy [32];
    logic [RW-1:0] n_tag  [32];

    register_file #(.ROB_WIDTH(RW)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_signal  (clear_signal),
        .issue_signal  (issue_signal),
        .issue_rd_id   (issue_rd_id),
        .issue_rob_tag (issue_rob_tag),
        .issue_rs1_id  (issue_rs1_id),
        .issue_rs2_id  (issue_rs2_id),
        .commit_signal (commit_signal),
        .commit_rd_id  (commit_rd_id),
        .commit_value  (commit_value),
        .commit_tag    (commit_tag),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'd0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    // Expected lookup result {value, busy, tag} for register id.
    function automatic logic [36:0] expect_of(input logic [4:0] id);
        logic [36:0] r;
        if (id == 5'd0) begin
            r = '0;
        end else if (commit_signal && commit_rd_id == id
                     && m_busy[id] && m_tag[id] == commit_tag) begin
            r = {commit_value, 1'b0, m_tag[id]};
        end else begin
            r = {m_val[id], m_busy[id], m_tag[id]};
        end
        return r;
    endfunction

    task automatic idle();
        rdy_in        = 1'b1;
        clear_signal  = 1'b0;
        issue_signal  = 1'b0;
        issue_rd_id   = 5'd0;
        issue_rob_tag = '0;
        commit_signal = 1'b0;
        commit_rd_id  = 5'd0;
        commit_value  = 32'd0;
        commit_tag    = '0;
    endtask

    // One rising edge; model applies the register-file rules.
    task automatic tick();
        for (int i = 0; i < 32; i++) begin
            n_val[i]  = m_val[i];
            n_busy[i] = m_busy[i];
            n_tag[i]  = m_tag[i];
        end
        if (rdy_in) begin
            if (commit_signal && commit_rd_id != 0)
                n_val[commit_rd_id] = commit_value;
            if (clear_signal) begin
                for (int i = 0; i < 32; i++) n_busy[i] = 1'b0;
            end else begin
                if (commit_signal && commit_rd_id != 0
                    && m_tag[commit_rd_id] == commit_tag
                    && !(issue_signal && issue_rd_id == commit_rd_id))
                    n_busy[commit_rd_id] = 1'b0;
                if (issue_signal && issue_rd_id != 0) begin
                    n_busy[issue_rd_id] = 1'b1;
                    n_tag[issue_rd_id]  = issue_rob_tag;
                end
            end
        end
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = n_val[i];
            m_busy[i] = n_busy[i];
            m_tag[i]  = n_tag[i];
        end
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        model_reset();
        issue_rs1_id = 5'd5;
        issue_rs2_id = 5'd0;
        repeat (2) @(negedge clk_in);
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== 37'd0) begin
            errors++;
            $display("FAIL reset_rs1 got %h/%b/%h want 0/0/0",
                     rs1_value, rs1_busy, rs1_tag);
        end
        checks++;
        if ({rs2_value, rs2_busy, rs2_tag} !== 37'd0) begin
            errors++;
            $display("FAIL reset_rs2 got %h/%b/%h want 0/0/0",
                     rs2_value, rs2_busy, rs2_tag);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_bypass();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd5; issue_rob_tag = 4'd3;
        tick();
        idle();
        issue_rs1_id = 5'd5;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd3) begin
            errors++;
            $display("FAIL issue_busy got %b/%h want 1/3",
                     rs1_busy, rs1_tag);
        end
        commit_signal = 1'b1; commit_rd_id = 5'd5;
        commit_tag = 4'd3; commit_value = 32'hDEADBEEF;
        #1;
        checks++;
        if (rs1_value !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL bypass got %h/%b want deadbeef/0",
                     rs1_value, rs1_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_value !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_commit got %h/%b want deadbeef/0",
                     rs1_value, rs1_busy);
        end
    endtask

    task automatic test_reissue();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd7; issue_rob_tag = 4'd1;
        tick();
        issue_rob_tag = 4'd2;
        tick();
        idle();
        issue_rs1_id = 5'd7;
        commit_signal = 1'b1; commit_rd_id = 5'd7;
        commit_tag = 4'd1; commit_value = 32'h11;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2
            || rs1_value !== 32'd0) begin
            errors++;
            $display("FAIL stale_no_bypass got %h/%b/%h want 0/1/2",
                     rs1_value, rs1_busy, rs1_tag);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_value !== 32'h11 || rs1_busy !== 1'b1
            || rs1_tag !== 4'd2) begin
            errors++;
            $display("FAIL stale_commit got %h/%b/%h want 11/1/2",
                     rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd9; issue_rob_tag = 4'd2;
        tick();
        issue_rob_tag = 4'd4;
        commit_signal = 1'b1; commit_rd_id = 5'd9;
        commit_tag = 4'd2; commit_value = 32'h55;
        issue_rs1_id = 5'd9;
        #1;
        checks++;
        if (rs1_value !== 32'h55 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL same_pre got %h/%b want 55/0",
                     rs1_value, rs1_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1_value !== 32'h55 || rs1_busy !== 1'b1
            || rs1_tag !== 4'd4) begin
            errors++;
            $display("FAIL same_post got %h/%b/%h want 55/1/4",
                     rs1_value, rs1_busy, rs1_tag);
        end
    endtask

    task automatic test_clear();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd3; issue_rob_tag = 4'd6;
        tick();
        issue_rd_id = 5'd4; issue_rob_tag = 4'd7;
        tick();
        clear_signal = 1'b1;
        issue_rd_id = 5'd6; issue_rob_tag = 4'd8;
        commit_signal = 1'b1; commit_rd_id = 5'd3;
        commit_tag = 4'd0; commit_value = 32'h77;
        tick();
        idle();
        issue_rs1_id = 5'd3;
        issue_rs2_id = 5'd4;
        #1;
        checks++;
        if (rs1_value !== 32'h77 || rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_r3 got %h/%b want 77/0",
                     rs1_value, rs1_busy);
        end
        checks++;
        if (rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_r4 busy got %b want 0", rs2_busy);
        end
        issue_rs1_id = 5'd6;
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_issue r6 busy got %b want 0", rs1_busy);
        end
    endtask

    task automatic test_x0_rdy();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd0; issue_rob_tag = 4'd5;
        commit_signal = 1'b1; commit_rd_id = 5'd0;
        commit_value = 32'hFF; commit_tag = 4'd5;
        issue_rs1_id = 5'd0;
        tick();
        idle();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== 37'd0) begin
            errors++;
            $display("FAIL x0 got %h/%b/%h want 0/0/0",
                     rs1_value, rs1_busy, rs1_tag);
        end
        rdy_in = 1'b0;
        issue_signal = 1'b1; issue_rd_id = 5'd8; issue_rob_tag = 4'd9;
        commit_signal = 1'b1; commit_rd_id = 5'd8;
        commit_value = 32'h1234; commit_tag = 4'd0;
        tick();
        idle();
        issue_rs1_id = 5'd8;
        #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_value !== 32'd0) begin
            errors++;
            $display("FAIL rdy_low got %h/%b want 0/0",
                     rs1_value, rs1_busy);
        end
    endtask

    task automatic test_random();
        logic [36:0] e1;
        logic [36:0] e2;
        for (int n = 0; n < 400; n++) begin
            rdy_in        = ($urandom_range(0, 9) != 0);
            clear_signal  = ($urandom_range(0, 19) == 0);
            issue_signal  = $urandom_range(0, 1) == 1;
            issue_rd_id   = 5'($urandom_range(0, 7));
            issue_rob_tag = 4'($urandom);
            commit_signal = $urandom_range(0, 1) == 1;
            commit_rd_id  = 5'($urandom_range(0, 7));
            commit_value  = $urandom;
            commit_tag    = ($urandom_range(0, 1) == 1)
                            ? m_tag[commit_rd_id] : 4'($urandom);
            issue_rs1_id  = 5'($urandom_range(0, 7));
            issue_rs2_id  = ($urandom_range(0, 1) == 1)
                            ? commit_rd_id : 5'($urandom_range(0, 7));
            #1;
            e1 = expect_of(issue_rs1_id);
            e2 = expect_of(issue_rs2_id);
            checks++;
            if (rs1_value !== e1[36:5] || rs1_busy !== e1[4]
                || ((e1[4] || issue_rs1_id == 0)
                    && rs1_tag !== e1[3:0])) begin
                errors++;
                $display("FAIL rand_rs1 n=%0d id=%0d got %h/%b/%h want %h/%b/%h",
                         n, issue_rs1_id, rs1_value, rs1_busy, rs1_tag,
                         e1[36:5], e1[4], e1[3:0]);
            end
            checks++;
            if (rs2_value !== e2[36:5] || rs2_busy !== e2[4]
                || ((e2[4] || issue_rs2_id == 0)
                    && rs2_tag !== e2[3:0])) begin
                errors++;
                $display("FAIL rand_rs2 n=%0d id=%0d got %h/%b/%h want %h/%b/%h",
                         n, issue_rs2_id, rs2_value, rs2_busy, rs2_tag,
                         e2[36:5], e2[4], e2[3:0]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        issue_signal = 1'b1; issue_rd_id = 5'd10; issue_rob_tag = 4'd5;
        issue_rs1_id = 5'd10;
        tick();
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({rs1_value, rs1_busy, rs1_tag} !== 37'd0) begin
            errors++;
            $display("FAIL async_reset got %h/%b/%h want 0/0/0",
                     rs1_value, rs1_busy, rs1_tag);
        end
        @(posedge clk_in);
        #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold busy got %b want 0", rs1_busy);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        tick();
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd5) begin
            errors++;
            $display("FAIL post_release got %b/%h want 1/5",
                     rs1_busy, rs1_tag);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        issue_rs1_id = 5'd0;
        issue_rs2_id = 5'd0;
        test_reset();
        test_bypass();
        test_reissue();
        test_same_cycle();
        test_clear();
        test_x0_rdy();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
